// File: rtl/add_sub_pkg.sv
// Shared op encodings, stage-count helper and result layout for the add/sub pipeline.
package add_sub_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     co;
        logic                     ovf;
        logic                     zero;
    } result_t;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle; slave is the adder side, master the producer/consumer side.
interface add_sub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, zero
    );
endinterface

// File: rtl/add_slice.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top bit.
// Zero latency, no flow control.
module add_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    always_comb begin : p_ripple
        logic c;
        c        = ci;
        c_msb_in = ci;
        s        = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple slice per stage; latency STAGES edges.
// Whole pipe advances only when the output slot is empty or being drained; in_ready mirrors that.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = 4
) (
    input logic           clk,
    input logic           rst,
    add_sub_pipe_if.slave bus
);
    localparam int STAGES = stages(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("add_sub_pipe: WIDTH must be a multiple of CHUNK");
    end

    // acc holds operand A above the processed chunks and finished sum chunks below them
    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] bb;
        logic             c;
    } beat_t;

    logic              advance;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_q;
    beat_t             stg_in [STAGES];
    beat_t             pipe_d [STAGES];
    beat_t             pipe_q [STAGES];
    logic [CHUNK-1:0]  slice_s  [STAGES];
    logic              slice_co [STAGES];
    logic              slice_cm [STAGES];
    logic [WIDTH-1:0]  b_x;
    logic              c_x;
    logic              co_d, ovf_d, zero_d;
    logic              co_q, ovf_q, zero_q;

    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    assign b_x = (bus.sub == OP_SUB) ? ~bus.b   : bus.b;
    assign c_x = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign vld_d[k]  = bus.in_valid;
            assign stg_in[k] = {bus.a, b_x, c_x};
        end else begin : g_next
            assign vld_d[k]  = vld_q[k-1];
            assign stg_in[k] = pipe_q[k-1];
        end

        add_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (stg_in[k].acc[k*CHUNK +: CHUNK]),
            .b        (stg_in[k].bb[k*CHUNK +: CHUNK]),
            .ci       (stg_in[k].c),
            .s        (slice_s[k]),
            .co       (slice_co[k]),
            .c_msb_in (slice_cm[k])
        );

        always_comb begin
            pipe_d[k]                          = stg_in[k];
            pipe_d[k].acc[k*CHUNK +: CHUNK]    = slice_s[k];
            pipe_d[k].c                        = slice_co[k];
        end
    end

    assign co_d   = slice_co[STAGES-1];
    assign ovf_d  = slice_co[STAGES-1] ^ slice_cm[STAGES-1];
    assign zero_d = (pipe_d[STAGES-1].acc == '0);

    // Data registers load only with a valid beat so bubbles leave stale data in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                if (vld_d[k]) begin
                    pipe_q[k] <= pipe_d[k];
                end
            end
            if (vld_d[STAGES-1]) begin
                co_q   <= co_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = pipe_q[STAGES-1].acc;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
